// File: rtl/mm_ram_arbiter_pkg.sv
// Shared types and constants for the matrix-RAM arbiter and its clients.
// Package name is mm_pkg so the control unit can import the same header layout.
package mm_pkg;

    // Owner FSM encoding
    typedef enum logic [1:0] {
        ARB_FREE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

    // Requester indices
    localparam logic PORT_HOST = 1'b0;
    localparam logic PORT_CU   = 1'b1;

    // Header word layout (word 0 of the RAM), shared with the control unit
    localparam int HDR_WORD_ADDR = 0;
    localparam int HDR_FIELD_W   = 8;
    localparam int HDR_M_LSB     = 0;
    localparam int HDR_N_LSB     = 8;
    localparam int HDR_K_LSB     = 16;
    localparam int HDR_GO_BIT    = 31;

    // Read-return tag travelling alongside the RAM read latency
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } rd_tag_t;

endpackage

// File: rtl/mm_ram_arbiter_if.sv
// Two-port requester bus of the matrix-RAM arbiter; port k occupies bit k / slice k.
interface mm_ram_arbiter_if #(
    parameter int data_w    = 32,
    parameter int ram_add_w = 9
);
    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0]             lock;
    logic [2*ram_add_w-1:0] addr;
    logic [2*data_w-1:0]    wdata;
    logic [1:0]             gnt;
    logic [1:0]             rvalid;
    logic [data_w-1:0]      rdata;
    logic [1:0]             addr_err;

    modport master (output req, we, lock, addr, wdata,
                    input  gnt, rvalid, rdata, addr_err);
    modport slave  (input  req, we, lock, addr, wdata,
                    output gnt, rvalid, rdata, addr_err);
endinterface

// File: rtl/mm_rd_tag_pipe.sv
// DEPTH-stage shift register carrying {valid, port, err} read tags so that
// returned RAM data can be routed to the port that issued the read.
module mm_rd_tag_pipe
    import mm_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset and flush drop everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this small array is reset (unlike a RAM) so no stale read survives reset.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mm_ram_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port matrix RAM
// between the host loader (port 0) and the multiply control unit (port 1).
// Optional macro MM_ARB_PERF_CNT_EN adds saturating grant/stall counters.
module mm_ram_arbiter
    import mm_pkg::*;
#(
    parameter int data_w    = 32,
    parameter int ram_d     = 512,
    parameter int ram_add_w = $clog2(ram_d),
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mm_ram_arbiter_if.slave      bus,
    output logic [ram_add_w-1:0] ram_addr,
    output logic                 ram_we,
    output logic [data_w-1:0]    ram_w_data,
    input  logic [data_w-1:0]    ram_r_data,
    output logic [15:0]          perf_gnt0,
    output logic [15:0]          perf_gnt1,
    output logic [15:0]          perf_stall
);

    localparam logic [ram_add_w:0] RAM_D_W    = (ram_add_w+1)'(ram_d);
    localparam logic [3:0]         BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t             state_q;
    logic                   rr_q;
    logic [3:0]             burst_q;
    logic [ram_add_w-1:0]   ram_addr_q;
    logic                   ram_we_q;
    logic [data_w-1:0]      ram_w_data_q;
    logic [1:0]             addr_err_q;
    rd_tag_t                tag_q;
    rd_tag_t                tag_ret;

    logic [1:0]             gnt_c;
    logic                   accept;
    logic                   acc_port;
    logic [ram_add_w-1:0]   sel_addr;
    logic [data_w-1:0]      sel_wdata;
    logic                   sel_we;
    logic                   sel_lock;
    logic                   oob;

    // Grant decode: round-robin when free, owner only when locked
    always_comb begin
        // NOTE: default assignment first so no path leaves gnt_c unassigned (no latch).
        gnt_c = '0;
        unique case (state_q)
            ARB_FREE:  gnt_c = (&bus.req) ? ((rr_q == PORT_CU) ? 2'b01 : 2'b10) : bus.req;
            ARB_LOCK0: gnt_c[PORT_HOST] = bus.req[PORT_HOST];
            ARB_LOCK1: gnt_c[PORT_CU]   = bus.req[PORT_CU];
            default:   gnt_c = '0;
        endcase
    end

    assign accept    = |(bus.req & gnt_c);
    assign acc_port  = gnt_c[PORT_CU];
    assign sel_addr  = acc_port ? bus.addr[2*ram_add_w-1:ram_add_w] : bus.addr[ram_add_w-1:0];
    assign sel_wdata = acc_port ? bus.wdata[2*data_w-1:data_w]      : bus.wdata[data_w-1:0];
    assign sel_we    = bus.we[acc_port];
    assign sel_lock  = bus.lock[acc_port];
    assign oob       = {1'b0, sel_addr} >= RAM_D_W;

    // Owner FSM, round-robin pointer and burst counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_FREE;
            rr_q    <= PORT_CU;
            burst_q <= '0;
        end else if (accept) begin
            // NOTE: sequential state uses <= so every register sees pre-edge values.
            rr_q <= acc_port;
            if (state_q == ARB_FREE) begin
                if (sel_lock) begin
                    state_q <= (acc_port == PORT_CU) ? ARB_LOCK1 : ARB_LOCK0;
                    burst_q <= 4'd1;
                end
            end else if (!sel_lock || burst_q >= BURST_LAST) begin
                state_q <= ARB_FREE;
                burst_q <= '0;
            end else begin
                burst_q <= burst_q + 4'd1;
            end
        end
    end

    // Registered RAM command, error pulse and read tag for the accepted access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_w_data_q <= '0;
            addr_err_q   <= '0;
            tag_q        <= '0;
        end else begin
            ram_we_q   <= accept && sel_we && !oob;
            addr_err_q <= (accept && oob) ? gnt_c : 2'b00;
            tag_q      <= '{valid: accept && !sel_we, port: acc_port, err: oob};
            if (accept) begin
                ram_addr_q   <= sel_addr;
                ram_w_data_q <= sel_wdata;
            end
        end
    end

    mm_rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .tag_i   (tag_q),
        .tag_o   (tag_ret)
    );

    assign ram_addr     = ram_addr_q;
    assign ram_we       = ram_we_q;
    assign ram_w_data   = ram_w_data_q;
    assign bus.gnt      = gnt_c;
    assign bus.addr_err = addr_err_q;
    assign bus.rvalid   = {tag_ret.valid && tag_ret.port, tag_ret.valid && !tag_ret.port};
    assign bus.rdata    = tag_ret.err ? '0 : ram_r_data;

`ifdef MM_ARB_PERF_CNT_EN
    logic [15:0] perf_gnt0_q;
    logic [15:0] perf_gnt1_q;
    logic [15:0] perf_stall_q;
    logic        stall;

    assign stall = |(bus.req & ~gnt_c);

    // Saturating accept-per-port and stall-cycle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_gnt0_q  <= '0;
            perf_gnt1_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept && acc_port == PORT_HOST && perf_gnt0_q != 16'hFFFF) perf_gnt0_q <= perf_gnt0_q + 16'd1;
            if (accept && acc_port == PORT_CU && perf_gnt1_q != 16'hFFFF)   perf_gnt1_q <= perf_gnt1_q + 16'd1;
            if (stall && perf_stall_q != 16'hFFFF)                          perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_gnt0  = perf_gnt0_q;
    assign perf_gnt1  = perf_gnt1_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_gnt0  = '0;
    assign perf_gnt1  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mm_ram_arbiter.sv
// Directed self-checking bench for mm_ram_arbiter (ram_d=500, RD_LAT=1, MAX_BURST=8).
module tb_mm_ram_arbiter;
    localparam int DW    = 32;
    localparam int RAM_D = 500;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data = '0;
    logic [15:0]   perf_gnt0, perf_gnt1, perf_stall;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [512];

    mm_ram_arbiter_if #(.data_w(DW), .ram_add_w(AW)) bus ();

    mm_ram_arbiter #(
        .data_w(DW), .ram_d(RAM_D), .ram_add_w(AW), .RD_LAT(1), .MAX_BURST(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data),
        .perf_gnt0  (perf_gnt0),
        .perf_gnt1  (perf_gnt1),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    // Single-port RAM model with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_w_data;
        ram_r_data <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req   = r;
        bus.we    = w;
        bus.lock  = l;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " gnt"},        32'(bus.gnt),      32'h0);
        check({tag, " rvalid"},     32'(bus.rvalid),   32'h0);
        check({tag, " addr_err"},   32'(bus.addr_err), 32'h0);
        check({tag, " ram_we"},     32'(ram_we),       32'h0);
        check({tag, " ram_addr"},   32'(ram_addr),     32'h0);
        check({tag, " ram_w_data"}, ram_w_data,        32'h0);
        check({tag, " perf_gnt0"},  32'(perf_gnt0),    32'h0);
        check({tag, " perf_gnt1"},  32'(perf_gnt1),    32'h0);
        check({tag, " perf_stall"}, 32'(perf_stall),   32'h0);
    endtask

    initial begin
        logic [1:0] exp_g;
        idle();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Write then read back through port 0
        @(negedge clk);
        drive(2'b01, 2'b01, 2'b00, 9'd5, '0, 32'hDEADBEEF, '0);
        #1 check("wr gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        check("wr ram_we", 32'(ram_we), 32'h1);
        check("wr ram_addr", 32'(ram_addr), 32'd5);
        check("wr ram_w_data", ram_w_data, 32'hDEADBEEF);
        drive(2'b01, 2'b00, 2'b00, 9'd5, '0, '0, '0);
        #1 check("rd gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        check("rd ram_we", 32'(ram_we), 32'h0);
        check("wr no rvalid", 32'(bus.rvalid), 32'h0);
        idle();
        @(negedge clk);
        check("rd rvalid", 32'(bus.rvalid), 32'h1);
        check("rd rdata", bus.rdata, 32'hDEADBEEF);
        @(negedge clk);
        check("rd rvalid end", 32'(bus.rvalid), 32'h0);

        // Fresh reset, then both ports read every cycle: strict alternation
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 2'b00, 9'd1, 9'd2, '0, '0);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            check("rr gnt", 32'(bus.gnt), 32'(exp_g));
            exp_g = (i < 2) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            check("rr rvalid route", 32'(bus.rvalid), 32'(exp_g));
        end
        @(negedge clk);
        idle();
`ifdef MM_ARB_PERF_CNT_EN
        check("perf_gnt0", 32'(perf_gnt0), 32'd4);
        check("perf_gnt1", 32'(perf_gnt1), 32'd4);
        check("perf_stall", 32'(perf_stall), 32'd8);
`else
        check("perf_gnt0 off", 32'(perf_gnt0), 32'd0);
        check("perf_gnt1 off", 32'(perf_gnt1), 32'd0);
        check("perf_stall off", 32'(perf_stall), 32'd0);
`endif
        repeat (2) @(negedge clk);

        // Port 1 burst of 8 with lock dropped on the last; port 0 waits throughout
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive((i == 0) ? 2'b10 : 2'b11, 2'b00, (i < 7) ? 2'b10 : 2'b00, 9'd3, 9'(10 + i), '0, '0);
            #1 check("burst gnt", 32'(bus.gnt), 32'h2);
        end
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 9'd3, '0, '0, '0);
        #1 check("post-burst gnt0", 32'(bus.gnt), 32'h1);

        // Port 1 holds lock: forced release after 8 accepts
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive((i == 0) ? 2'b10 : 2'b11, 2'b00, 2'b10, 9'd4, 9'(20 + i), '0, '0);
            #1 check("forced burst gnt", 32'(bus.gnt), 32'h2);
        end
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b10, 9'd4, 9'd28, '0, '0);
        #1 check("forced release gnt0", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(2'b10, 2'b00, 2'b10, 9'd4, 9'(28 + i), '0, '0);
            #1 check("relock gnt1", 32'(bus.gnt), 32'h2);
        end
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 9'd4, '0, '0, '0);
        #1 check("idle owner keeps lock", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 9'd4, 9'd40, '0, '0);
        #1 check("owner release gnt1", 32'(bus.gnt), 32'h2);

        // Out-of-range read on port 0
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 9'd511, '0, '0, '0);
        #1 check("oob gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        idle();
        check("oob addr_err", 32'(bus.addr_err), 32'h1);
        check("oob ram_we", 32'(ram_we), 32'h0);
        @(negedge clk);
        check("oob rvalid", 32'(bus.rvalid), 32'h1);
        check("oob rdata", bus.rdata, 32'h0);
        check("oob addr_err end", 32'(bus.addr_err), 32'h0);

        // Reset one cycle after a read accept
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 9'd5, '0, 32'h0000_1234, '0);
        #1 check("pre-reset gnt", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1 check_reset_outputs("mid reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no stale rvalid", 32'(bus.rvalid), 32'h0);
        end
        drive(2'b11, 2'b00, 2'b00, 9'd6, 9'd7, '0, '0);
        #1 check("first gnt after reset", 32'(bus.gnt), 32'h1);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
